// File: rtl/traffic_pkg.sv
// Light codes shared between the traffic-light controller and its road-side sensors.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED     = 2'd0,
        LIGHT_YELLOW  = 2'd1,
        LIGHT_GREEN   = 2'd2,
        LIGHT_ILLEGAL = 2'd3
    } light_t;

endpackage

// File: rtl/det_debounce.sv
// Two-flop synchroniser plus level debouncer for the raw loop detector.
// arr pulses for one cycle whenever a new high level is accepted.
module det_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic det_raw,
    output logic det_q,
    output logic arr
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             det_s;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            sync1 <= 1'b0;
            det_s <= 1'b0;
            det_q <= 1'b0;
            cnt   <= '0;
            arr   <= 1'b0;
        end else begin
            sync1 <= det_raw;
            det_s <= sync1;
            arr   <= 1'b0;
            if (det_s == det_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                det_q <= det_s;
                cnt   <= '0;
                arr   <= det_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cntry_vehicle_sensor.sv
// Country-road vehicle sensor: counts debounced arrivals, drains them at a fixed
// rate under country green, and raises x while enough vehicles are waiting.
module cntry_vehicle_sensor
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned DRAIN_CYC    = 3,
    parameter int unsigned QUEUE_W      = 4,
    parameter int unsigned X_THRESH     = 1
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               det_raw,
    input  logic [1:0]         cntry,
    output logic               x,
    output logic [QUEUE_W-1:0] vcount,
    output logic               overflow,
    output logic               lt_err
);

    localparam int unsigned TMR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(DRAIN_CYC - 1);
    localparam logic [QUEUE_W-1:0] VMAX     = '1;
    localparam logic [QUEUE_W-1:0] THRESH   = QUEUE_W'(X_THRESH);

    light_t             light;
    logic               arr;
    logic               dep;
    logic               ovf_set;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_next;
    logic [QUEUE_W-1:0] vcount_next;

    det_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk    (clk),
        .clear_n(clear_n),
        .det_raw(det_raw),
        .det_q  (),
        .arr    (arr)
    );

    assign light = light_t'(cntry);

    // Illegal code 3 falls through to the no-drain branch, same as red.
    always_comb begin
        dep        = 1'b0;
        timer_next = '0;
        if (light == LIGHT_GREEN && vcount != '0) begin
            if (timer == TMR_LAST) begin
                dep = 1'b1;
            end else begin
                timer_next = timer + 1'b1;
            end
        end
    end

    always_comb begin
        vcount_next = vcount;
        ovf_set     = 1'b0;
        if (arr && !dep) begin
            if (vcount == VMAX) begin
                ovf_set = 1'b1;
            end else begin
                vcount_next = vcount + 1'b1;
            end
        end else if (dep && !arr) begin
            vcount_next = vcount - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            timer    <= '0;
            vcount   <= '0;
            x        <= 1'b0;
            overflow <= 1'b0;
            lt_err   <= 1'b0;
        end else begin
            timer  <= timer_next;
            vcount <= vcount_next;
            x      <= (vcount_next >= THRESH);
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (light == LIGHT_ILLEGAL) begin
                lt_err <= 1'b1;
            end
        end
    end

endmodule
